logic_unit_pipe: RTL and testbench

// - Parametrised, pipelined successor to the single-bit AND gate in the branch path.
// - Performs one of eight bitwise/logic ops on two WIDTH-bit operands, split into LANES equal lanes.
// - Two registered stages with valid/ready handshakes on both sides; per-lane zero flags for branch/compare use.
// - Wrapping completed-op counter for debug/perf; sits between decode and writeback/branch-resolve logic.

---
 rtl/lu_pkg.sv | 15 +
 rtl/logic_lane_op.sv | 32 +++
 rtl/logic_unit_pipe.sv | 94 +++++++++
 tb/tb_logic_unit_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared op encodings for the pipelined logic unit.
// Pure definitions; no latency or flow control of its own.
// Imported by the lane datapath and the pipeline top.
package lu_pkg;
    localparam int LU_OPW = 3;

    localparam logic [LU_OPW-1:0] LU_AND   = 3'd0;
    localparam logic [LU_OPW-1:0] LU_OR    = 3'd1;
    localparam logic [LU_OPW-1:0] LU_XOR   = 3'd2;
    localparam logic [LU_OPW-1:0] LU_NOR   = 3'd3;
    localparam logic [LU_OPW-1:0] LU_ANDN  = 3'd4;
    localparam logic [LU_OPW-1:0] LU_ORN   = 3'd5;
    localparam logic [LU_OPW-1:0] LU_XNOR  = 3'd6;
    localparam logic [LU_OPW-1:0] LU_PASSA = 3'd7;
endpackage

// File: rtl/logic_lane_op.sv
// One lane of the bitwise op datapath plus its all-zero flag.
// Purely combinational, zero latency.
// No flow control; the enclosing pipeline owns the handshakes.
module logic_lane_op
    import lu_pkg::*;
#(
    parameter int LW = 32
) (
    input  logic [LU_OPW-1:0] op,
    input  logic [LW-1:0]     a,
    input  logic [LW-1:0]     b,
    output logic [LW-1:0]     res,
    output logic              zero
);

    always_comb begin
        res = a;
        case (op)
            LU_AND:   res = a & b;
            LU_OR:    res = a | b;
            LU_XOR:   res = a ^ b;
            LU_NOR:   res = ~(a | b);
            LU_ANDN:  res = a & ~b;
            LU_ORN:   res = a | ~b;
            LU_XNOR:  res = ~(a ^ b);
            LU_PASSA: res = a;
            default:  res = a;
        endcase
        zero = (res == '0);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with per-lane zero flags and op counter.
// Latency 2 cycles from input handshake to out_valid; 1 op/cycle throughput.
// in_ready is combinational from out_ready (no skid); outputs hold while stalled.
module logic_unit_pipe
    import lu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1,
    parameter int CNTW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LU_OPW-1:0] in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_res,
    output logic [LANES-1:0]  out_zero,
    input  logic              cnt_clr,
    output logic [CNTW-1:0]   cnt_done
);

    localparam int LW = WIDTH / LANES;

    typedef struct packed {
        logic [LU_OPW-1:0] op;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
    } s1_t;

    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic             s2_adv;
    logic             out_fire;
    logic [WIDTH-1:0] res_d;
    logic [LANES-1:0] zero_d;

    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Zero flags come from the result being loaded into S2, never from S2 itself.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic_lane_op #(.LW(LW)) u_lane (
            .op   (s1_q.op),
            .a    (s1_q.a[l*LW +: LW]),
            .b    (s1_q.b[l*LW +: LW]),
            .res  (res_d[l*LW +: LW]),
            .zero (zero_d[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{op: in_op, a: in_a, b: in_b};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_zero <= '0;
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            out_res  <= res_d;
            out_zero <= zero_d;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_done <= '0;
        end else if (cnt_clr) begin
            cnt_done <= '0;
        end else if (out_fire) begin
            cnt_done <= cnt_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench driving a 1-lane and a 4-lane instance in lockstep against a table and a reference model.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;

    logic        in_ready1, in_ready4, out_valid1, out_valid4;
    logic [31:0] res1, res4;
    logic [0:0]  zero1;
    logic [3:0]  zero4;
    logic [15:0] cnt1, cnt4;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32), .LANES(1), .CNTW(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid1),
        .out_ready(out_ready), .out_res(res1), .out_zero(zero1),
        .cnt_clr(cnt_clr), .cnt_done(cnt1)
    );

    logic_unit_pipe #(.WIDTH(32), .LANES(4), .CNTW(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid4),
        .out_ready(out_ready), .out_res(res4), .out_zero(zero4),
        .cnt_clr(cnt_clr), .cnt_done(cnt4)
    );

    typedef struct {
        logic [31:0] res;
        logic        z1;
        logic [3:0]  z4;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z1;
        logic [3:0]  z4;
    } vec_t;

    int          passed = 0;
    int          total = 0;
    int          n_out = 0;
    int          cyc = 0;
    logic        acc_flag = 1'b0;
    logic [15:0] cnt_exp = '0;
    exp_t        nxt_exp;
    exp_t        exp_q[$];
    vec_t        tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, req);
    endtask

    // Reference: the op table applied to whole words, zero flags by byte inspection.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = a ^ b;
            3'd3: e.res = ~(a | b);
            3'd4: e.res = a & ~b;
            3'd5: e.res = a | ~b;
            3'd6: e.res = ~(a ^ b);
            default: e.res = a;
        endcase
        e.z1 = (e.res == 32'd0);
        for (int l = 0; l < 4; l++) e.z4[l] = (e.res[8*l +: 8] == 8'd0);
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc_flag = in_valid && in_ready1;
        if (out_valid1 && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL pop_order: output with nothing pending, actual res=%h required none", res1);
            end else begin
                e = exp_q.pop_front();
                chk("res1", res1, e.res);
                chk("zero1", {31'd0, zero1}, {31'd0, e.z1});
                chk("res4", res4, e.res);
                chk("zero4", {28'd0, zero4}, {28'd0, e.z4});
                chk("valid4", {31'd0, out_valid4}, 32'd1);
            end
        end
        if (acc_flag) exp_q.push_back(nxt_exp);
        if (cnt_clr) cnt_exp = '0;
        else if (out_valid1 && out_ready) cnt_exp++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        in_op = op; in_a = a; in_b = b; nxt_exp = e;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        set_item(op, a, b, e);
        in_valid = 1'b1;
        acc_flag = 1'b0;
        for (int k = 0; k < 20 && !acc_flag; k++) cycle();
        chk("send_accept", {31'd0, acc_flag}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        exp_t        e;
        int          c0, n0, acc, k, miss;
        logic [2:0]  sop[4];
        logic [31:0] sa[4], sb[4];

        tbl[0] = '{3'd0, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF, 1'b0, 4'b1110};
        tbl[1] = '{3'd1, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFFFF, 1'b0, 4'b1000};
        tbl[2] = '{3'd2, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b0, 4'b1001};
        tbl[3] = '{3'd3, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 1'b0, 4'b0111};
        tbl[4] = '{3'd4, 32'h0000FFFF, 32'h00FF00FF, 32'h0000FF00, 1'b0, 4'b1101};
        tbl[5] = '{3'd5, 32'h0000FFFF, 32'h00FF00FF, 32'hFF00FFFF, 1'b0, 4'b0100};
        tbl[6] = '{3'd6, 32'h0000FFFF, 32'h00FF00FF, 32'hFF0000FF, 1'b0, 4'b0110};
        tbl[7] = '{3'd7, 32'h0000FFFF, 32'h00FF00FF, 32'h0000FFFF, 1'b0, 4'b1100};
        tbl[8] = '{3'd2, 32'h12345678, 32'h12AB5678, 32'h009F0000, 1'b0, 4'b1011};
        tbl[9] = '{3'd2, 32'hCAFEBABE, 32'hCAFEBABE, 32'h00000000, 1'b1, 4'b1111};

        // Reset state
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        chk("rst_in_ready4", {31'd0, in_ready4}, 32'd1);
        chk("rst_out_res", res1, 32'd0);
        chk("rst_out_zero4", {28'd0, zero4}, 32'd0);
        chk("rst_cnt", {16'd0, cnt1}, 32'd0);

        // Single AND: two-cycle latency, counter reaches 1
        out_ready = 1'b1;
        set_item(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 1'b0, 4'b0101});
        in_valid = 1'b1;
        cycle();
        chk("lat_accept", {31'd0, acc_flag}, 32'd1);
        in_valid = 1'b0;
        chk("lat_cycle1_valid", {31'd0, out_valid1}, 32'd0);
        cycle();
        chk("lat_cycle2_valid", {31'd0, out_valid1}, 32'd1);
        chk("lat_res", res1, 32'hF000F000);
        cycle();
        chk("lat_cnt", {16'd0, cnt1}, 32'd1);
        chk("lat_cnt4", {16'd0, cnt4}, 32'd1);

        // Op sweep back-to-back: one accept and one result per cycle
        c0 = cyc; n0 = n_out;
        for (int i = 0; i < 8; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, '{tbl[i].res, tbl[i].z1, tbl[i].z4});
        chk("sweep_cycles", cyc - c0, 32'd8);
        cycle(); cycle();
        chk("sweep_outputs", n_out - n0, 32'd8);
        drain();

        // Remaining table rows, including the lane-2 XOR case
        for (int i = 8; i < 10; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, '{tbl[i].res, tbl[i].z1, tbl[i].z4});
        drain();

        // Stall during a burst
        for (int i = 0; i < 4; i++) begin
            sop[i] = 3'(i + 1); sa[i] = $urandom; sb[i] = $urandom;
        end
        out_ready = 1'b0;
        acc = 0; k = 0;
        set_item(sop[0], sa[0], sb[0], model(sop[0], sa[0], sb[0]));
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (acc_flag) begin
                acc++; k++;
                set_item(sop[k], sa[k], sb[k], model(sop[k], sa[k], sb[k]));
            end
        end
        e = model(sop[0], sa[0], sb[0]);
        chk("stall_accepts", acc, 32'd2);
        chk("stall_in_ready", {31'd0, in_ready1}, 32'd0);
        chk("stall_in_ready4", {31'd0, in_ready4}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid1}, 32'd1);
        chk("stall_out_res", res1, e.res);
        chk("stall_out_zero4", {28'd0, zero4}, {28'd0, e.z4});
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            cycle();
            if (acc_flag) begin
                k++;
                if (k < 4) set_item(sop[k], sa[k], sb[k], model(sop[k], sa[k], sb[k]));
            end
        end
        chk("stall_all_sent", k, 32'd4);
        drain();

        // Randomised traffic with random backpressure
        in_valid = 1'b0; acc_flag = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc_flag) begin
                if ($urandom_range(3) != 0) begin
                    logic [2:0]  rop;
                    logic [31:0] ra, rb;
                    rop = 3'($urandom_range(7));
                    ra = $urandom;
                    rb = ($urandom_range(1) == 1) ? (ra ^ (32'hFF << (8 * $urandom_range(3)))) : $urandom;
                    set_item(rop, ra, rb, model(rop, ra, rb));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        drain();
        chk("rand_cnt", {16'd0, cnt1}, {16'd0, cnt_exp});

        // Reset with both stages full
        out_ready = 1'b0;
        send(3'd1, 32'h1, 32'h2, model(3'd1, 32'h1, 32'h2));
        send(3'd2, 32'h3, 32'h4, model(3'd2, 32'h3, 32'h4));
        chk("full_in_ready", {31'd0, in_ready1}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("arst_out_valid4", {31'd0, out_valid4}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready1}, 32'd1);
        chk("arst_cnt", {16'd0, cnt1}, 32'd0);
        exp_q.delete();
        cnt_exp = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready1}, 32'd1);
        chk("post_rst_res", res1, 32'd0);
        chk("post_rst_cnt4", {16'd0, cnt4}, 32'd0);

        // Counter wrap: 65535 handshakes to FFFF, one more to 0
        out_ready = 1'b1; miss = 0;
        for (int i = 0; i < 65535; i++) begin
            logic [2:0]  wop;
            logic [31:0] wa;
            wop = 3'(i);
            wa = i;
            set_item(wop, wa, ~wa, model(wop, wa, ~wa));
            in_valid = 1'b1;
            cycle();
            if (!acc_flag) miss++;
        end
        in_valid = 1'b0;
        drain();
        chk("wrap_misses", miss, 32'd0);
        chk("wrap_cnt_ffff", {16'd0, cnt1}, 32'h0000FFFF);
        send(3'd7, 32'hA5A5A5A5, 32'h0, model(3'd7, 32'hA5A5A5A5, 32'h0));
        drain();
        chk("wrap_cnt_zero", {16'd0, cnt1}, 32'd0);
        chk("wrap_cnt4_zero", {16'd0, cnt4}, 32'd0);

        // Clear colliding with an output handshake
        send(3'd0, 32'hFF, 32'hFF, model(3'd0, 32'hFF, 32'hFF));
        drain();
        chk("clr_pre_cnt", {16'd0, cnt1}, 32'd1);
        out_ready = 1'b0;
        send(3'd1, 32'h0, 32'h0, model(3'd1, 32'h0, 32'h0));
        cycle();
        chk("clr_held_valid", {31'd0, out_valid1}, 32'd1);
        out_ready = 1'b1; cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_cnt", {16'd0, cnt1}, 32'd0);
        chk("clr_cnt_model", {16'd0, cnt1}, {16'd0, cnt_exp});
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
